bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adj.sv | 22 ++
 rtl/bcd_to_bin_seq.sv | 175 +++++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants and state encoding for the BCD <-> binary
//                sequential converters (decoder and encoder side).
//                BCD_DIGIT_W    - bits per packed BCD digit
//                BCD_MAX_DIGIT  - largest legal BCD digit value
//                BCD_ADJ_THRESH - reverse double-dabble adjust threshold
//                BCD_ADJ        - value subtracted when the threshold is met
//                bcd_state_e    - IDLE / CONV / DONE converter states
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Combinational per-digit correction for reverse double-dabble.
//                After a right shift, a digit that received a bit from the
//                digit above holds value+8 where value+5 is meant, so any
//                digit >= 8 has 3 subtracted (4-bit, no borrow out).
//  Ports       : digit_in  [3:0] - shifted BCD digit
//                digit_out [3:0] - corrected BCD digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in - BCD_ADJ) : digit_in;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_seq
//  Description : Sequential packed-BCD to unsigned binary converter using
//                iterative reverse double-dabble, one result bit per clock.
//                valid/ready handshake on input and output; result latency is
//                BIN_W cycles after the acceptance edge.
//  Config      : `define BCD_CHECK_EN to flag words containing a digit > 9
//                (result bin_out=0, err=1, one-cycle latency). Without it err
//                is tied low and such words run the normal algorithm.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                in_valid/in_ready/bcd_in    - input handshake + packed BCD
//                                              (digit 0 in bcd_in[3:0])
//                out_valid/out_ready/bin_out/err - result handshake
//                busy            - conversion in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BIN_W-1:0]            bin_out,
    output logic                        err,
    output logic                        busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SR_W  = BCD_W + BIN_W;

    bcd_state_e          r_state;
    bcd_state_e          w_next_state;
    logic [BCD_W-1:0]    r_bcd;
    logic [BIN_W-1:0]    r_bin;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]    r_bin_out;

    logic [SR_W-1:0]     w_shifted;
    logic [BCD_W-1:0]    w_shift_bcd;
    logic [BIN_W-1:0]    w_shift_bin;
    logic [BCD_W-1:0]    w_adj_bcd;
    logic                w_last;
    logic                w_bad_digit;

    // ------------------------------------------------------------------
    // One iteration: shift {bcd, bin} right, then correct every digit.
    // ------------------------------------------------------------------
    assign w_shifted   = {r_bcd, r_bin} >> 1;
    assign w_shift_bcd = w_shifted[SR_W-1 -: BCD_W];
    assign w_shift_bin = w_shifted[BIN_W-1:0];

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_in  (w_shift_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (w_adj_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

`ifdef BCD_CHECK_EN
    always_comb begin
        w_bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
                w_bad_digit = 1'b1;
            end
        end
    end
`else
    assign w_bad_digit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = w_bad_digit ? DONE : CONV;
                end
            end
            CONV: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bcd <= bcd_in;
                        r_bin <= '0;
                        r_cnt <= '0;
                        // Rejected words skip CONV, so the result is forced here.
                        if (w_bad_digit) begin
                            r_bin_out <= '0;
                        end
                    end
                end
                CONV: begin
                    r_bcd <= w_adj_bcd;
                    r_bin <= w_shift_bin;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bin_out <= w_shift_bin;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && in_valid) begin
            r_err <= w_bad_digit;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == CONV);
    assign out_valid = (r_state == DONE);
    assign bin_out   = r_bin_out;

endmodule : bcd_to_bin_seq
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin_seq
//  Description : Self-checking bench for bcd_to_bin_seq (DIGITS=3, BIN_W=10).
//                Expected results come from decimal arithmetic on the BCD
//                digits; define BCD_CHECK_EN together with the RTL to cover
//                the invalid-digit reporting build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
`ifdef BCD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      bcd_in;
    logic             out_valid;
    logic             out_ready;
    logic [BIN_W-1:0] bin_out;
    logic             err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int bcd_value(input logic [11:0] w);
        return int'(w[3:0]) + 10 * int'(w[7:4]) + 100 * int'(w[11:8]);
    endfunction

    function automatic bit bcd_legal(input logic [11:0] w);
        return (w[3:0] <= 9) && (w[7:4] <= 9) && (w[11:8] <= 9);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one word through, reports observed latency/result and the
    // number of handshake-signal violations seen along the way.
    task automatic convert(input logic [11:0] w, input int hold,
                           output int lat, output logic [BIN_W-1:0] bin,
                           output logic e, output int bad);
        int n;
        bad = 0;
        n   = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        in_valid = 1'b1;
        bcd_in   = w;
        step();
        in_valid = 1'b0;
        bcd_in   = 12'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            if (in_ready || !busy) bad++;
            step();
            n++;
        end
        lat = n;
        bin = bin_out;
        e   = err;
        repeat (hold) begin
            step();
            if (!out_valid || in_ready || bin_out !== bin || err !== e) bad++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (out_valid || !in_ready) bad++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({in_ready, out_valid, busy, err} !== 4'b1000 || bin_out !== '0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b err=%b bin_out=%0d, expected 1 0 0 0 0",
                     in_ready, out_valid, busy, err, bin_out);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_known(input logic [11:0] w, input int hold, input string name);
        int lat, bad;
        logic [BIN_W-1:0] bin;
        logic e;
        convert(w, hold, lat, bin, e, bad);
        checks++;
        if (lat !== BIN_W) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, BIN_W);
        end
        checks++;
        if (bin !== BIN_W'(bcd_value(w)) || e !== 1'b0) begin
            errors++;
            $display("FAIL %s result: got %0d err=%b expected %0d err=0", name, bin, e, bcd_value(w));
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s handshake: %0d violations, expected 0", name, bad);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        in_valid = 1'b1;
        bcd_in   = 12'h010;
        step();
        bcd_in = 12'h509;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n !== BIN_W || bin_out !== 10'd10) begin
            errors++;
            $display("FAIL b2b first: latency %0d result %0d expected %0d / 10", n, bin_out, BIN_W);
        end
        step();
        step();
        checks++;
        if (!out_valid || in_ready || bin_out !== 10'd10) begin
            errors++;
            $display("FAIL b2b held: out_valid=%b in_ready=%b bin_out=%0d expected 1 0 10",
                     out_valid, in_ready, bin_out);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid || !in_ready) begin
            errors++;
            $display("FAIL b2b release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n !== BIN_W || bin_out !== 10'd509) begin
            errors++;
            $display("FAIL b2b second: latency %0d result %0d expected %0d / 509", n, bin_out, BIN_W);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_invalid();
        int lat, bad;
        logic [BIN_W-1:0] bin;
        logic e;
        convert(12'h1A3, 2, lat, bin, e, bad);
        checks++;
        if (e !== CHECK_EN || lat !== (CHECK_EN ? 0 : BIN_W)) begin
            errors++;
            $display("FAIL invalid: err=%b latency=%0d expected err=%b latency=%0d",
                     e, lat, CHECK_EN, CHECK_EN ? 0 : BIN_W);
        end
`ifdef BCD_CHECK_EN
        checks++;
        if (bin !== '0) begin
            errors++;
            $display("FAIL invalid result: got %0d expected 0", bin);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        in_valid = 1'b1;
        bcd_in   = 12'h777;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (!busy) begin
            errors++;
            $display("FAIL midreset pre: busy=%b expected 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (!in_ready || out_valid || busy || bin_out !== '0) begin
            errors++;
            $display("FAIL midreset: in_ready=%b out_valid=%b busy=%b bin_out=%0d expected 1 0 0 0",
                     in_ready, out_valid, busy, bin_out);
        end
        seen = 0;
        repeat (15) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midreset output: out_valid seen %0d cycles expected 0", seen);
        end
        test_known(12'h042, 0, "after_reset");
    endtask

    task automatic test_random();
        int lat, bad;
        logic [BIN_W-1:0] bin;
        logic e;
        logic [11:0] w;
        bit legal;
        for (int i = 0; i < 24; i++) begin
            w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 4) == 0) w[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            legal = bcd_legal(w);
            convert(w, $urandom_range(0, 3), lat, bin, e, bad);
            checks++;
            if (lat !== ((!legal && CHECK_EN) ? 0 : BIN_W) || e !== (!legal && CHECK_EN) || bad !== 0) begin
                errors++;
                $display("FAIL random[%0d] %h: latency=%0d err=%b violations=%0d", i, w, lat, e, bad);
            end
            if (legal) begin
                checks++;
                if (bin !== BIN_W'(bcd_value(w))) begin
                    errors++;
                    $display("FAIL random[%0d] %h: got %0d expected %0d", i, w, bin, bcd_value(w));
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        test_reset();
        test_known(12'h000, 0, "zero");
        test_known(12'h999, 0, "max");
        test_known(12'h255, 5, "backpressure");
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bcd_to_bin_seq
`default_nettype wire
